note_sequencer: RTL
===================

// Module: note_sequencer
//
// PURPOSE
//   Parametrised, programmable step sequencer for the synth voice path. It plays a
//   NUM_STEPS-entry note pattern, advancing one step per step_tick strobe from the
//   tempo clock divider. sound_edge toggles run/stop. It adds loop/one-shot mode,
//   reverse play, rest steps, runtime pattern writes and an end-of-sequence pulse.
//   Its note_out code feeds the oscillator/frequency lookup stage.
//
// PARAMETERS
//   NUM_STEPS  8                     pattern length; legal range >=2, any integer
//   NOTE_W     4                     note code width (semitone index)
//   REST_CODE  {NOTE_W{1'b1}}        code meaning "silent step"
//   IDX_W      $clog2(NUM_STEPS)     step index width; derived, never overridden
//
// PORTS
//   clk         in   1        system clock
//   n_rst       in   1        reset, synchronous, active-low
//   sound_edge  in   1        one-cycle pulse; toggles run/stop
//   step_tick   in   1        one-cycle tempo strobe; advances the step
//   loop_en     in   1        1: wrap at end of pattern; 0: stop at end
//   reverse     in   1        1: play descending indices
//   wr_en       in   1        pattern write strobe
//   wr_addr     in   IDX_W    pattern entry to write
//   wr_note     in   NOTE_W   note code to write
//   note_out    out  NOTE_W   current note; REST_CODE when idle
//   note_valid  out  1        1 = PLAY and current entry != REST_CODE
//   step_idx    out  IDX_W    current step index; 0 when idle
//   seq_done    out  1        one-cycle pulse at pattern end or wrap
//
// BEHAVIOUR
//   Reset (n_rst=0 at a clk edge): state=IDLE, step_idx=0, seq_done=0.
//     Pattern entries 0..7 reset to {0,2,4,5,7,9,11,12} (C major, low C to high C).
//     Entries >=8 reset to REST_CODE. Reset wins over any same-cycle write or strobe.
//   Outputs: note_out, note_valid and step_idx decode registered state, step_idx and
//     pattern only. No input reaches an output combinationally. seq_done is a register.
//   FSM states: IDLE, PLAY.
//   IDLE:
//     - note_out=REST_CODE, note_valid=0, step_idx=0. step_tick is ignored.
//     - On sound_edge: go to PLAY next cycle.
//       step_idx = reverse ? NUM_STEPS-1 : 0.
//     - step_tick in the same cycle as that sound_edge is ignored.
//   PLAY:
//     - note_out = pattern[step_idx].
//     - sound_edge: go to IDLE next cycle, step_idx=0, no seq_done.
//       sound_edge beats a simultaneous step_tick.
//     - step_tick when not at the last step: step_idx +1, or -1 if reverse=1.
//       reverse is sampled on every tick.
//     - Last step = NUM_STEPS-1 when forward, 0 when reverse.
//     - step_tick at the last step:
//         loop_en=1: wrap to the first step of the current direction.
//         loop_en=0: go to IDLE.
//       In both cases seq_done=1 for exactly the next cycle.
//   Index never leaves 0..NUM_STEPS-1, including when NUM_STEPS is not a power of two.
//   Latency:
//     - sound_edge or step_tick at edge k -> new step_idx/note_out visible after edge k+1.
//   Pattern writes:
//     - wr_en writes pattern[wr_addr]=wr_note at the clk edge, in any state.
//     - wr_addr >= NUM_STEPS is ignored.
//     - A write to the playing step shows on note_out the cycle after the write edge.
//     - A same-cycle step_tick advances as normal.
//   Rest steps: a REST_CODE entry holds its time slot with note_valid=0.
//
// TESTING
//   1 Reset, start, 8 ticks, loop_en=0:
//     note_out 0,2,4,5,7,9,11,12, then IDLE with note_out=15.
//     seq_done pulses once, one cycle after the 8th tick.
//   2 loop_en=1, reverse=1, start, 9 ticks:
//     step_idx 7,6,...,0,7,6. seq_done pulses after the 8th tick only.
//   3 wr_en addr=3 note=15 while playing step 3:
//     next cycle note_out=15, note_valid=0; next tick -> step 4, note_out=7.
//   4 sound_edge and step_tick in the same cycle during PLAY step 2:
//     IDLE, step_idx=0, no seq_done.
//     The same pair in IDLE: PLAY at step 0, with no advance.
//   5 NUM_STEPS=5, loop_en=1, 6 ticks:
//     step_idx 0..4 then 0, never 5..7.
//     wr_addr=6 is ignored.
//   6 n_rst=0 mid-PLAY together with wr_en:
//     IDLE, step_idx=0, pattern restored to its reset values.

Source files
------------

// File: rtl/note_sequencer.sv
// note_sequencer
//   Programmable NUM_STEPS-entry note pattern player for the synth voice path.
//   Advances one step per step_tick while playing; sound_edge toggles run/stop.
//   Supports loop/one-shot mode, reverse play, rest steps (REST_CODE entries),
//   runtime pattern writes and a one-cycle end-of-sequence pulse.
//
// Ports
//   clk         system clock
//   n_rst       synchronous active-low reset
//   sound_edge  one-cycle pulse, toggles run/stop
//   step_tick   one-cycle tempo strobe, advances the step while playing
//   loop_en     1: wrap at pattern end, 0: stop at pattern end
//   reverse     1: play descending indices (sampled on every tick)
//   wr_en       pattern write strobe
//   wr_addr     pattern entry to write (>= NUM_STEPS ignored)
//   wr_note     note code to write
//   note_out    current note, REST_CODE when idle
//   note_valid  playing and current entry is not a rest
//   step_idx    current step index, 0 when idle
//   seq_done    one-cycle pulse after the tick that ends or wraps the pattern
module note_sequencer #(
    parameter int                NUM_STEPS = 8,
    parameter int                NOTE_W    = 4,
    parameter logic [NOTE_W-1:0] REST_CODE = {NOTE_W{1'b1}},
    localparam int               IDX_W     = $clog2(NUM_STEPS)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              sound_edge,
    input  logic              step_tick,
    input  logic              loop_en,
    input  logic              reverse,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [NOTE_W-1:0] wr_note,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_valid,
    output logic [IDX_W-1:0]  step_idx,
    output logic              seq_done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PLAY = 1'b1;

    localparam logic [IDX_W-1:0] LAST_FWD = IDX_W'(NUM_STEPS - 1);

    // Power-up pattern: C major scale low C to high C, rests beyond.
    function automatic logic [NOTE_W-1:0] reset_note(input int i);
        case (i)
            0:       return NOTE_W'(0);
            1:       return NOTE_W'(2);
            2:       return NOTE_W'(4);
            3:       return NOTE_W'(5);
            4:       return NOTE_W'(7);
            5:       return NOTE_W'(9);
            6:       return NOTE_W'(11);
            7:       return NOTE_W'(12);
            default: return REST_CODE;
        endcase
    endfunction

    logic [0:0]                       state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic                             done_q, done_d;
    logic [NUM_STEPS-1:0][NOTE_W-1:0] pat_q, pat_d;

    logic             at_last;
    logic [IDX_W-1:0] first_idx;
    logic             wr_ok;

    // Direction-dependent end points; reverse is taken live on each tick.
    assign at_last   = reverse ? (idx_q == '0) : (idx_q == LAST_FWD);
    assign first_idx = reverse ? LAST_FWD : '0;
    // Out-of-range addresses matter when NUM_STEPS is not a power of two.
    assign wr_ok     = wr_en && (int'(wr_addr) < NUM_STEPS);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        pat_d   = pat_q;

        if (wr_ok) begin
            pat_d[wr_addr] = wr_note;
        end

        case (state_q)
            IDLE: begin
                // A tick arriving with the start edge is dropped.
                if (sound_edge) begin
                    state_d = PLAY;
                    idx_d   = first_idx;
                end
            end
            default: begin
                if (sound_edge) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (step_tick) begin
                    if (at_last) begin
                        done_d = 1'b1;
                        if (loop_en) begin
                            idx_d = first_idx;
                        end else begin
                            state_d = IDLE;
                            idx_d   = '0;
                        end
                    end else if (reverse) begin
                        idx_d = idx_q - 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_STEPS; i++) begin
                pat_q[i] <= reset_note(i);
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            pat_q   <= pat_d;
        end
    end

    assign note_out   = (state_q == PLAY) ? pat_q[idx_q] : REST_CODE;
    assign note_valid = (state_q == PLAY) && (pat_q[idx_q] != REST_CODE);
    assign step_idx   = idx_q;
    assign seq_done   = done_q;

endmodule
